// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-index busy scoreboard, write forwarding, debug tap and write counter
module regfile_sb #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int DBG_IDX = 10,
  parameter int BYPASS  = 1,
  parameter int CNT_W   = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] AD1,
  input  logic [ADDR_W-1:0] AD2,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2,
  input  logic [ADDR_W-1:0] AD3,
  input  logic              WE3,
  input  logic [WIDTH-1:0]  WD3,
  input  logic              BS_EN,
  input  logic [ADDR_W-1:0] BS_AD,
  output logic              HAZ1,
  output logic              HAZ2,
  output logic [WIDTH-1:0]  dbg,
  output logic [CNT_W-1:0]  wr_cnt
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_sb: DEPTH must be a power of two and at least 2");
  end
  if (DBG_IDX < 0 || DBG_IDX >= DEPTH) begin : g_bad_dbg_idx
    $error("regfile_sb: DBG_IDX must index an existing register");
  end

  localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_IDX);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_commit;
  logic             hit1;
  logic             hit2;

  // Index 0 is never a write target; reset gates everything so inputs are ignored while low.
  assign wr_commit = rst_n & WE3 & (AD3 != '0);
  assign hit1      = wr_commit & (AD3 == AD1);
  assign hit2      = wr_commit & (AD3 == AD2);

  // Next busy vector: a completing write clears, a newly issued producer sets and wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (wr_commit) busy_d[AD3] = 1'b0;
    if (rst_n && BS_EN && (BS_AD != '0)) busy_d[BS_AD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Register array; entry 0 stays at its reset value of zero forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      regs_q[AD3] <= WD3;
    end
  end

  // Scoreboard busy bits and saturating committed-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_commit && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Combinational read ports with optional forwarding of the in-flight write.
  always_comb begin
    RD1 = regs_q[AD1];
    RD2 = regs_q[AD2];
    if (BYPASS != 0) begin
      if (hit1) RD1 = WD3;
      if (hit2) RD2 = WD3;
    end
  end

  // Hazard flags: forwarding hides a completing producer, otherwise the write itself is still in flight.
  always_comb begin
    if (BYPASS != 0) begin
      HAZ1 = busy_q[AD1] & ~hit1;
      HAZ2 = busy_q[AD2] & ~hit2;
    end else begin
      HAZ1 = busy_q[AD1] | hit1;
      HAZ2 = busy_q[AD2] | hit2;
    end
  end

  assign dbg    = regs_q[DBG_A];
  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb, forwarding and non-forwarding builds side by side
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  AD1 = '0, AD2 = '0, AD3 = '0, BS_AD = '0;
  logic        WE3 = 1'b0, BS_EN = 1'b0;
  logic [31:0] WD3 = '0;

  logic [31:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b;
  logic        haz1_a, haz2_a, haz1_b, haz2_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  regfile_sb u_dut_a (
    .clk(clk), .rst_n(rst_n), .AD1(AD1), .AD2(AD2), .RD1(rd1_a), .RD2(rd2_a),
    .AD3(AD3), .WE3(WE3), .WD3(WD3), .BS_EN(BS_EN), .BS_AD(BS_AD),
    .HAZ1(haz1_a), .HAZ2(haz2_a), .dbg(dbg_a), .wr_cnt(cnt_a)
  );

  regfile_sb #(.BYPASS(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .AD1(AD1), .AD2(AD2), .RD1(rd1_b), .RD2(rd2_b),
    .AD3(AD3), .WE3(WE3), .WD3(WD3), .BS_EN(BS_EN), .BS_AD(BS_AD),
    .HAZ1(haz1_b), .HAZ2(haz2_b), .dbg(dbg_b), .wr_cnt(cnt_b)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rd1, rd2, dbg, rd1b, rd2b;
    logic        h1, h2, h1b, h2b;
    logic [15:0] cnt;
    logic [3:0]  cntb;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_cnt;

  function automatic logic [31:0] m_rd(int a, bit byp, bit rst, bit we, int ad3, logic [31:0] wd);
    if (!rst || a == 0) return 32'h0;
    if (byp && we && ad3 != 0 && ad3 == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_haz(int a, bit byp, bit rst, bit we, int ad3);
    bit wr_here;
    if (!rst || a == 0) return 1'b0;
    wr_here = we && ad3 != 0 && ad3 == a;
    if (byp) return m_busy[a] && !wr_here;
    return m_busy[a] || wr_here;
  endfunction

  task automatic step(input bit rst, input bit we, input int ad3, input logic [31:0] wd,
                      input int ad1, input int ad2, input bit bse, input int bsad);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; WE3 = we; AD3 = 5'(ad3); WD3 = wd;
    AD1 = 5'(ad1); AD2 = 5'(ad2); BS_EN = bse; BS_AD = 5'(bsad);
    cyc++;
    e.cyc  = cyc;
    e.rd1  = m_rd(ad1, 1, rst, we, ad3, wd);
    e.rd2  = m_rd(ad2, 1, rst, we, ad3, wd);
    e.rd1b = m_rd(ad1, 0, rst, we, ad3, wd);
    e.rd2b = m_rd(ad2, 0, rst, we, ad3, wd);
    e.h1   = m_haz(ad1, 1, rst, we, ad3);
    e.h2   = m_haz(ad2, 1, rst, we, ad3);
    e.h1b  = m_haz(ad1, 0, rst, we, ad3);
    e.h2b  = m_haz(ad2, 0, rst, we, ad3);
    e.dbg  = rst ? m_regs[10] : 32'h0;
    e.cnt  = rst ? 16'((m_cnt > 65535) ? 65535 : m_cnt) : 16'h0;
    e.cntb = rst ? 4'((m_cnt > 15) ? 15 : m_cnt) : 4'h0;
    exp_q.push_back(e);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      if (we && ad3 != 0) begin
        m_regs[ad3] = wd;
        m_busy[ad3] = 1'b0;
        m_cnt++;
      end
      if (bse && bsad != 0) m_busy[bsad] = 1'b1;
    end
  endtask

  task automatic idle(input int ad1, input int ad2);
    step(1, 0, 0, 32'h0, ad1, ad2, 0, 0);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // Monitor: the DUT presents outputs every cycle; compare mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd1",    e.cyc, rd1_a, e.rd1);
      chk("rd2",    e.cyc, rd2_a, e.rd2);
      chk("haz1",   e.cyc, 32'(haz1_a), 32'(e.h1));
      chk("haz2",   e.cyc, 32'(haz2_a), 32'(e.h2));
      chk("dbg",    e.cyc, dbg_a, e.dbg);
      chk("wr_cnt", e.cyc, 32'(cnt_a), 32'(e.cnt));
      chk("rd1_nb", e.cyc, rd1_b, e.rd1b);
      chk("rd2_nb", e.cyc, rd2_b, e.rd2b);
      chk("haz1_nb", e.cyc, 32'(haz1_b), 32'(e.h1b));
      chk("haz2_nb", e.cyc, 32'(haz2_b), 32'(e.h2b));
      chk("dbg_nb", e.cyc, dbg_b, e.dbg);
      chk("wr_cnt_nb", e.cyc, 32'(cnt_b), 32'(e.cntb));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;

    // Reset held: writes and producer marks must be ignored.
    step(0, 1, 10, 32'hA5A5A5A5, 10, 10, 1, 10);
    step(0, 1, 5, 32'h11111111, 5, 0, 1, 5);

    // Forwarding of a write on the first active edge, then array read-back.
    step(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
    idle(5, 5);

    // Writes and producer marks aimed at index 0 have no effect.
    step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    idle(0, 0);

    // Producer on 7 raises the hazard until its write lands.
    step(1, 0, 0, 32'h0, 0, 0, 1, 7);
    idle(7, 7);
    step(1, 1, 7, 32'h12, 0, 7, 0, 0);
    idle(7, 7);

    // New producer on 9 issued in the same cycle as the old one's write: stays busy.
    step(1, 0, 0, 32'h0, 0, 0, 1, 9);
    step(1, 1, 9, 32'h99, 9, 9, 1, 9);
    idle(9, 9);
    step(1, 0, 0, 32'h0, 9, 0, 1, 9);
    idle(9, 0);

    // Debug tap, then asynchronous reset mid-sequence with a write and producer pending.
    step(1, 1, 10, 32'h55, 10, 0, 1, 3);
    idle(10, 3);
    step(0, 1, 10, 32'h77, 10, 3, 1, 4);
    step(0, 0, 0, 32'h0, 3, 4, 0, 0);
    idle(10, 3);

    // Twenty committed writes saturate the narrow counter.
    for (int i = 0; i < 20; i++) step(1, 1, (i % 31) + 1, $urandom, i % 32, 10, 0, 0);
    idle(1, 2);

    // Randomized traffic over a narrow address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom,
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 2) == 0, $urandom_range(0, 15));
    end
    idle(0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter DEPTH, default 32, register count; power of two, >=2; ADDR_W = clog2(DEPTH).
REQ-003 Parameter DBG_IDX, default 10, register index driven on dbg.
REQ-004 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-005 Parameter CNT_W, default 16, width of the write counter.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 AD1, AD2  input  ADDR_W  read port addresses.
REQ-009 RD1, RD2  output  WIDTH  read port data.
REQ-010 AD3  input  ADDR_W  write address.
REQ-011 WE3  input  1  write enable.
REQ-012 WD3  input  WIDTH  write data.
REQ-013 BS_EN  input  1  mark destination pending (producer issued).
REQ-014 BS_AD  input  ADDR_W  destination to mark pending.
REQ-015 HAZ1, HAZ2  output  1  read port operand not yet valid.
REQ-016 dbg  output  WIDTH  current contents of register DBG_IDX.
REQ-017 wr_cnt  output  CNT_W  count of committed writes.

Function
REQ-018 Index 0 SHALL read as zero on every port, never be written, never be marked pending.
REQ-019 Committed write = WE3 & (AD3 != 0); SHALL update reg[AD3] <= WD3 at next rising edge; visible in array the cycle after.
REQ-020 Reads SHALL be combinational; if BYPASS=1 and committed write targets ADx this cycle, RDx SHALL equal WD3, else reg[ADx].
REQ-021 Scoreboard: one busy bit per index; committed write SHALL clear busy[AD3]; BS_EN & (BS_AD != 0) SHALL set busy[BS_AD].
REQ-022 Set and clear to the same index in the same cycle: set SHALL win (newer producer outstanding).
REQ-023 Set to an already-busy index SHALL leave it busy (no nesting count).
REQ-024 HAZx SHALL be busy[ADx] & ~(BYPASS & committed write to ADx this cycle); ADx = 0 SHALL give HAZx = 0.
REQ-025 With BYPASS=0, committed write to ADx this cycle SHALL additionally assert HAZx.
REQ-026 dbg SHALL be reg[DBG_IDX] (array value, no bypass); DBG_IDX >= DEPTH is an elaboration error.
REQ-027 wr_cnt SHALL increment by 1 per committed write and saturate at 2^CNT_W-1.
REQ-028 Writes with AD3 = 0 SHALL not count and not affect any busy bit.
REQ-029 RD1 and RD2 SHALL be independent; AD1 = AD2 SHALL return identical data and hazard.

Reset
REQ-030 rst_n low SHALL immediately clear all registers, all busy bits and wr_cnt to 0, regardless of clk.
REQ-031 During reset: RD1 = RD2 = dbg = 0, HAZ1 = HAZ2 = 0, wr_cnt = 0; WE3 and BS_EN ignored.
REQ-032 Deassertion SHALL take effect synchronously; first write accepted on first rising edge with rst_n high.
REQ-033 Reset asserted mid-sequence (busy bits set, write pending) SHALL discard the pending write and all busy state.

Verification
REQ-034 Reset then WE3=1, AD3=5, WD3=0xDEADBEEF, AD1=5 same cycle -> RD1=0xDEADBEEF (BYPASS=1); next cycle WE3=0 -> RD1=0xDEADBEEF, wr_cnt=1.
REQ-035 WE3=1, AD3=0, WD3=0xFFFFFFFF; AD1=0 -> RD1=0 now and after edge; wr_cnt unchanged; BS_EN with BS_AD=0 -> HAZ1 stays 0.
REQ-036 BS_EN=1, BS_AD=7; next cycle AD2=7 -> HAZ2=1; write AD3=7 WD3=0x12 -> HAZ2=0 same cycle, RD2=0x12; busy clear after edge.
REQ-037 Same cycle BS_EN=1 BS_AD=9 and write AD3=9 with busy[9]=1 -> after edge HAZ1=1 for AD1=9, reg[9] holds written data.
REQ-038 Write AD3=10 WD3=0x55 -> dbg=0x55 next cycle; assert rst_n low between edges -> dbg=0, wr_cnt=0, all HAZ=0 immediately.
REQ-039 CNT_W=4: 20 committed writes -> wr_cnt=15 and held; BYPASS=0 build: write to AD1 -> HAZ1=1, RD1=old value.
